// File: rtl/gol_pkg.sv
// Shared grid geometry, seed patterns and state encodings for the Life display.
package gol_pkg;

  localparam int unsigned GRID    = 10;
  localparam int unsigned CELLS   = GRID * GRID;
  localparam int unsigned LEDS    = 64;
  localparam int unsigned COLOR_W = 24;

  // Bit r*10+c of a plane holds cell (row r, col c).
  localparam logic [CELLS-1:0] SEED_R =
    (100'(1) << 12) | (100'(1) << 23) | (100'(1) << 31) |
    (100'(1) << 32) | (100'(1) << 33);
  localparam logic [CELLS-1:0] SEED_G =
    (100'(1) << 54) | (100'(1) << 55) | (100'(1) << 56);
  localparam logic [CELLS-1:0] SEED_B =
    (100'(1) << 77) | (100'(1) << 78) | (100'(1) << 87) | (100'(1) << 88);

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_COMMIT} gen_state_t;
  typedef enum logic {WS_SEND, WS_LATCH} ws_state_t;

  function automatic logic [6:0] idx(input int unsigned r, input int unsigned c);
    return 7'(r * GRID + c);
  endfunction

endpackage

// File: rtl/game_of_life_ws2812.sv
// WS2812 serializer: snapshots 64 GRB words per frame, sends them MSB first,
// then holds the line low for the latch gap.
module ws2812_driver
  import gol_pkg::*;
#(
  parameter int T0H    = 4,
  parameter int T1H    = 8,
  parameter int TBIT   = 15,
  parameter int TRESET = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LEDS*COLOR_W-1:0] i_colors,
  output logic                    o_data,
  output logic [5:0]              o_pixel
);

  localparam int CW = $clog2(TBIT);
  localparam int LW = $clog2(TRESET);
  localparam int IW = $clog2(LEDS * COLOR_W);
  localparam logic [CW-1:0] TBIT_LAST   = CW'(TBIT - 1);
  localparam logic [CW-1:0] T0H_C       = CW'(T0H);
  localparam logic [CW-1:0] T1H_C       = CW'(T1H);
  localparam logic [LW-1:0] TRESET_LAST = LW'(TRESET - 1);
  localparam logic [4:0]    BIT_LAST    = 5'(COLOR_W - 1);
  localparam logic [5:0]    LED_LAST    = 6'(LEDS - 1);

  ws_state_t               r_state, w_next_state;
  logic [CW-1:0]           r_cyc;
  logic [4:0]              r_bit;
  logic [5:0]              r_led;
  logic [LW-1:0]           r_latch;
  logic [LEDS*COLOR_W-1:0] r_snap;
  logic                    w_bit_end, w_led_end, w_frame_end, w_latch_end;
  logic [IW-1:0]           w_bit_idx;

  assign w_bit_end   = (r_cyc == TBIT_LAST);
  assign w_led_end   = w_bit_end && (r_bit == BIT_LAST);
  assign w_frame_end = w_led_end && (r_led == LED_LAST);
  assign w_latch_end = (r_latch == '0);
  assign w_bit_idx   = IW'(r_led) * IW'(COLOR_W) + IW'(BIT_LAST - r_bit);

  // State register; reset enters a zero-length latch so the first frame
  // snapshots the freshly reset planes one cycle later.
  always_ff @(posedge clk) begin
    if (rst) r_state <= WS_LATCH;
    else     r_state <= w_next_state;
  end

  // Next-state: frame of 64 LEDs, then the latch gap.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      WS_SEND:  if (w_frame_end) w_next_state = WS_LATCH;
      WS_LATCH: if (w_latch_end) w_next_state = WS_SEND;
      default:  w_next_state = WS_LATCH;
    endcase
  end

  // Outputs: pulse width chosen by the current bit; pixel index only while sending.
  always_comb begin
    o_data  = 1'b0;
    o_pixel = '0;
    if (r_state == WS_SEND) begin
      o_data  = (r_cyc < (r_snap[w_bit_idx] ? T1H_C : T0H_C));
      o_pixel = r_led;
    end
  end

  // Bit, LED and latch counters plus the frame snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc   <= '0;
      r_bit   <= '0;
      r_led   <= '0;
      r_latch <= '0;
      r_snap  <= '0;
    end else begin
      case (r_state)
        WS_SEND: begin
          if (w_bit_end) begin
            r_cyc <= '0;
            if (w_led_end) begin
              r_bit <= '0;
              if (w_frame_end) begin
                r_led   <= '0;
                r_latch <= TRESET_LAST;
              end else begin
                r_led <= r_led + 1'b1;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
        end
        WS_LATCH: begin
          if (w_latch_end) r_snap  <= i_colors;
          else             r_latch <= r_latch - 1'b1;
        end
        default: r_latch <= '0;
      endcase
    end
  end

endmodule

// File: rtl/game_of_life_top.sv
// Conway's Game of Life on three 10x10 colour planes, shown on an 8x8 WS2812 matrix.
module game_of_life_top
  import gol_pkg::*;
#(
  parameter int         GEN_CYCLES = 6000000,
  parameter int         T0H        = 4,
  parameter int         T1H        = 8,
  parameter int         TBIT       = 15,
  parameter int         TRESET     = 1000,
  parameter logic [7:0] BRIGHT     = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SW,
  input  logic        BOOT,
  output logic        _48b,
  output logic        _45a,
  output logic [99:0] current_state_r_out,
  output logic [99:0] current_state_g_out,
  output logic [99:0] current_state_b_out,
  output logic [4:0]  column_out_r,
  output logic [4:0]  column_out_g,
  output logic [4:0]  column_out_b,
  output logic [5:0]  pixel_out
);

  localparam int GW = (GEN_CYCLES > 1) ? $clog2(GEN_CYCLES) : 1;
  localparam logic [GW-1:0] GEN_LAST = GW'(GEN_CYCLES - 1);
  localparam logic [3:0]    COL_LAST = 4'(GRID - 1);

  logic             r_sw_s1, r_sw_s2, r_boot_s1, r_boot_s2;
  logic [GW-1:0]    r_gen_cnt;
  gen_state_t       r_state, w_next_state;
  logic [3:0]       r_col, w_col_out;
  logic             w_calc_en, w_commit, w_tick, w_boot;
  logic [CELLS-1:0] r_cur_r, r_cur_g, r_cur_b;
  logic [CELLS-1:0] r_next_r, r_next_g, r_next_b;
  logic [GRID-1:0]  w_col_r, w_col_g, w_col_b;
  logic             r_beat;
  logic [LEDS*COLOR_W-1:0] w_colors;

  // Next-generation value of every cell in column c; border rows/cols stay dead.
  function automatic logic [GRID-1:0] life_col(input logic [CELLS-1:0] s,
                                               input logic [3:0] c);
    logic [GRID-1:0] col;
    int unsigned n;
    int unsigned cc;
    col = '0;
    cc  = 32'(c);
    if (cc >= 1 && cc <= GRID - 2) begin
      for (int unsigned r = 1; r <= GRID - 2; r++) begin
        n = 0;
        for (int unsigned dr = 0; dr < 3; dr++) begin
          for (int unsigned dc = 0; dc < 3; dc++) begin
            if (!(dr == 1 && dc == 1))
              n += 32'(s[idx(r + dr - 1, cc + dc - 1)]);
          end
        end
        col[4'(r)] = (n == 3) || (n == 2 && s[idx(r, cc)]);
      end
    end
    return col;
  endfunction

  assign w_tick = (r_gen_cnt == GEN_LAST) && r_sw_s2;
  assign w_boot = ~r_boot_s2;

  assign w_col_r = life_col(r_cur_r, r_col);
  assign w_col_g = life_col(r_cur_g, r_col);
  assign w_col_b = life_col(r_cur_b, r_col);

  // Two-flop synchronizers for the asynchronous buttons (idle level is high).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sw_s1   <= 1'b1;
      r_sw_s2   <= 1'b1;
      r_boot_s1 <= 1'b1;
      r_boot_s2 <= 1'b1;
    end else begin
      r_sw_s1   <= SW;
      r_sw_s2   <= r_sw_s1;
      r_boot_s1 <= BOOT;
      r_boot_s2 <= r_boot_s1;
    end
  end

  // Engine state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Engine next-state: reseed overrides everything, including COMMIT.
  always_comb begin
    w_next_state = r_state;
    if (w_boot) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (w_tick) w_next_state = ST_CALC;
        ST_CALC:   if (r_col == COL_LAST) w_next_state = ST_COMMIT;
        ST_COMMIT: w_next_state = ST_IDLE;
        default:   w_next_state = ST_IDLE;
      endcase
    end
  end

  // Engine outputs decoded from the current state.
  always_comb begin
    w_calc_en = (r_state == ST_CALC);
    w_commit  = (r_state == ST_COMMIT);
    w_col_out = w_calc_en ? r_col : '0;
  end

  // Tick counter, column sweep into the next buffers, and generation commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_r   <= SEED_R;
      r_cur_g   <= SEED_G;
      r_cur_b   <= SEED_B;
      r_next_r  <= '0;
      r_next_g  <= '0;
      r_next_b  <= '0;
      r_col     <= '0;
      r_gen_cnt <= '0;
      r_beat    <= 1'b0;
    end else if (w_boot) begin
      r_cur_r   <= SEED_R;
      r_cur_g   <= SEED_G;
      r_cur_b   <= SEED_B;
      r_col     <= '0;
      r_gen_cnt <= '0;
    end else begin
      r_gen_cnt <= (r_gen_cnt == GEN_LAST) ? '0 : r_gen_cnt + 1'b1;
      if (w_calc_en) begin
        for (int unsigned r = 0; r < GRID; r++) begin
          r_next_r[idx(r, 32'(r_col))] <= w_col_r[4'(r)];
          r_next_g[idx(r, 32'(r_col))] <= w_col_g[4'(r)];
          r_next_b[idx(r, 32'(r_col))] <= w_col_b[4'(r)];
        end
        r_col <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
      end
      if (w_commit) begin
        r_cur_r <= r_next_r;
        r_cur_g <= r_next_g;
        r_cur_b <= r_next_b;
        r_beat  <= ~r_beat;
      end
    end
  end

  // LED k shows interior cell (1 + k/8, 1 + k%8) as a GRB word.
  always_comb begin
    w_colors = '0;
    for (int unsigned k = 0; k < LEDS; k++) begin
      w_colors[11'(k * COLOR_W) +: COLOR_W] = {
        r_cur_g[idx(1 + k / 8, 1 + k % 8)] ? BRIGHT : 8'h00,
        r_cur_r[idx(1 + k / 8, 1 + k % 8)] ? BRIGHT : 8'h00,
        r_cur_b[idx(1 + k / 8, 1 + k % 8)] ? BRIGHT : 8'h00
      };
    end
  end

  ws2812_driver #(
    .T0H    (T0H),
    .T1H    (T1H),
    .TBIT   (TBIT),
    .TRESET (TRESET)
  ) u_ws (
    .clk      (clk),
    .rst      (rst),
    .i_colors (w_colors),
    .o_data   (_48b),
    .o_pixel  (pixel_out)
  );

  assign _45a                = r_beat;
  assign current_state_r_out = r_cur_r;
  assign current_state_g_out = r_cur_g;
  assign current_state_b_out = r_cur_b;
  assign column_out_r        = {1'b0, w_col_out};
  assign column_out_g        = {1'b0, w_col_out};
  assign column_out_b        = {1'b0, w_col_out};

endmodule

// File: tb/tb_game_of_life_top.sv
// Directed bench for game_of_life_top: reset state, WS2812 frame timing,
// generation evolution, pause and reseed behaviour.
module tb_game_of_life_top;

  logic        clk = 1'b0;
  logic        rst, SW, BOOT;
  logic        d48b, hb45a;
  logic [99:0] pr, pg, pb;
  logic [4:0]  col_r, col_g, col_b;
  logic [5:0]  pixel_out;

  int tests = 0;
  int fails = 0;
  int cyc;
  int n, hi, cyc_b, col_bad, beat_bad;
  bit shape, pix_ok, pixbad;
  logic [99:0] seed_r, seed_g, seed_b, gen1_r, gen4_r, gen5_r, vert_g, border;
  logic [99:0] hold_r, hold_g, hold_b;
  logic        hold_beat;

  game_of_life_top #(.GEN_CYCLES(20)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .SW                  (SW),
    .BOOT                (BOOT),
    ._48b                (d48b),
    ._45a                (hb45a),
    .current_state_r_out (pr),
    .current_state_g_out (pg),
    .current_state_b_out (pb),
    .column_out_r        (col_r),
    .column_out_g        (col_g),
    .column_out_b        (col_b),
    .pixel_out           (pixel_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [99:0] bm(input int a);
    return 100'(1) << a;
  endfunction

  task automatic check(input string tag, input logic [99:0] obs, input logic [99:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Samples one 15-cycle bit slot; reports high count and whether it is high-then-low.
  task automatic capture_bit(input int led, output int h, output bit shp, output bit pok);
    bit seen_low;
    h = 0; shp = 1'b1; pok = 1'b1; seen_low = 1'b0;
    for (int t = 0; t < 15; t++) begin
      @(negedge clk);
      if (d48b === 1'b1) begin
        h++;
        if (seen_low) shp = 1'b0;
      end else begin
        seen_low = 1'b1;
      end
      if (pixel_out !== 6'(led)) pok = 1'b0;
    end
  endtask

  task automatic wait_beat(input int bound);
    logic prev;
    int k;
    prev = hb45a;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (hb45a === prev && k < bound);
    check("beat_timeout", 100'(k < bound), 100'(1));
  endtask

  initial begin
    seed_r = bm(12) | bm(23) | bm(31) | bm(32) | bm(33);
    seed_g = bm(54) | bm(55) | bm(56);
    seed_b = bm(77) | bm(78) | bm(87) | bm(88);
    gen1_r = bm(21) | bm(23) | bm(32) | bm(33) | bm(42);
    gen4_r = bm(23) | bm(34) | bm(42) | bm(43) | bm(44);
    gen5_r = bm(32) | bm(34) | bm(43) | bm(44) | bm(53);
    vert_g = bm(45) | bm(55) | bm(65);
    border = '0;
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        if (r == 0 || r == 9 || c == 0 || c == 9) border |= bm(r * 10 + c);

    // Phase A: reset, then first WS2812 frame.
    rst = 1'b1; SW = 1'b1; BOOT = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_red", pr, seed_r);
    check("rst_green", pg, seed_g);
    check("rst_blue", pb, seed_b);
    check("rst_48b", d48b, 0);
    check("rst_pixel", pixel_out, 0);
    check("rst_col", {col_r, col_g, col_b}, 0);
    check("rst_45a", hb45a, 0);
    rst = 1'b0;

    for (int b = 0; b < 24; b++) begin
      capture_bit(0, hi, shape, pix_ok);
      check("led0_high", hi, 4);
      check("led0_shape_pix", {shape, pix_ok}, 2'b11);
    end
    for (int b = 0; b < 24; b++) begin
      capture_bit(1, hi, shape, pix_ok);
      check("led1_high", hi, (b == 11) ? 8 : 4);
      check("led1_shape_pix", {shape, pix_ok}, 2'b11);
    end

    n = 0;
    while (pixel_out !== 6'd63 && n < 30000) begin @(negedge clk); n++; end
    check("reach_led63", 100'(n < 30000), 100'(1));
    n = 0;
    while (pixel_out === 6'd63 && n < 400) begin @(negedge clk); n++; end
    check("led63_end", 100'(n < 400), 100'(1));
    n = 0; pixbad = 1'b0;
    while (d48b === 1'b0 && n < 2000) begin
      if (pixel_out !== 6'd0) pixbad = 1'b1;
      n++;
      @(negedge clk);
    end
    check("latch_len", n, 1000);
    check("latch_pixel", pixbad, 0);
    check("frame2_start", {d48b, pixel_out}, {1'b1, 6'd0});

    // Phase B: reset in mid-frame, then generation tests.
    rst = 1'b1;
    @(negedge clk);
    check("rst2_planes", {pr ^ seed_r} | {pg ^ seed_g} | {pb ^ seed_b}, 0);
    check("rst2_outs", {d48b, hb45a, pixel_out, col_r}, 0);
    rst = 1'b0;

    n = 0;
    while (col_r !== 5'd1 && n < 100) begin @(negedge clk); n++; end
    check("calc_start_cyc", cyc, 21);
    for (int i = 2; i <= 9; i++) begin
      @(negedge clk);
      check("col_r_sweep", col_r, i);
      check("col_gb_sweep", {col_g, col_b}, {5'(i), 5'(i)});
    end
    @(negedge clk);
    check("commit_col", col_r, 0);
    check("commit_not_yet", hb45a, 0);
    @(negedge clk);
    check("gen1_45a", hb45a, 1);
    check("gen1_latency", cyc, 31);
    check("gen1_red", pr, gen1_r);
    check("gen1_green", pg, vert_g);
    check("gen1_blue", pb, seed_b);

    repeat (3) wait_beat(40);
    check("gen4_red", pr, gen4_r);
    check("gen4_green", pg, seed_g);
    check("gen4_blue", pb, seed_b);
    check("gen4_border", (pr | pg | pb) & border, 0);
    check("gen4_45a", hb45a, 0);

    // Pause across three tick periods.
    SW = 1'b0;
    hold_r = pr; hold_g = pg; hold_b = pb; hold_beat = hb45a;
    col_bad = 0; beat_bad = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (col_r !== 5'd0) col_bad++;
      if (hb45a !== hold_beat) beat_bad++;
    end
    check("pause_planes", (pr ^ hold_r) | (pg ^ hold_g) | (pb ^ hold_b), 0);
    check("pause_beat_col", {beat_bad, col_bad}, 0);
    SW = 1'b1;

    wait_beat(60);
    check("gen5_red", pr, gen5_r);
    check("gen5_green", pg, vert_g);

    // One-cycle reseed pulse.
    BOOT = 1'b0;
    @(negedge clk);
    BOOT = 1'b1;
    @(negedge clk);
    check("boot_sync_delay", pr, gen5_r);
    @(negedge clk);
    check("boot_red", pr, seed_r);
    check("boot_gb", {pg, pb}, {seed_g, seed_b});
    cyc_b = cyc;
    wait_beat(60);
    check("boot_counter_clear", cyc, cyc_b + 31);
    check("post_boot_green", pg, vert_g);
    check("post_boot_red", pr, gen1_r);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
